lsu_data_memory: RTL and testbench

- Parametrised next-generation data memory for the RV32I core. It replaces the always-ready word RAM with a request/response memory that supports byte, half and word loads and stores, using the RV32I funct3 encoding.
- Load results are sign- or zero-extended.
- Misaligned, out-of-range and illegal-size accesses are reported as errors.
- Access latency is a configurable number of wait states.
- The block sits between the core's memory stage and the byte-addressed data region of the memory map.

---
 rtl/mem_pkg.sv | 43 ++++
 rtl/lsu_align.sv | 61 ++++++
 rtl/lsu_data_memory.sv | 190 +++++++++++++++++++
 tb/tb_lsu_data_memory.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the LSU data memory: RV32I load/store
// size encodings, FSM state encoding, access sizes and alignment rules.
package mem_pkg;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } mem_state_t;

    // Access sizes in bytes; SIZE_NONE marks an illegal funct3.
    localparam logic [2:0] SIZE_NONE = 3'd0;
    localparam logic [2:0] SIZE_BYTE = 3'd1;
    localparam logic [2:0] SIZE_HALF = 3'd2;
    localparam logic [2:0] SIZE_WORD = 3'd4;

    function automatic logic [2:0] access_size(funct3_t f3);
        case (f3)
            F3_B, F3_BU: return SIZE_BYTE;
            F3_H, F3_HU: return SIZE_HALF;
            F3_W:        return SIZE_WORD;
            default:     return SIZE_NONE;
        endcase
    endfunction

    // Halfwords need an even address, words a 4-byte aligned one.
    function automatic logic is_misaligned(funct3_t f3, logic [1:0] addr_lo);
        case (f3)
            F3_H, F3_HU: return addr_lo[0];
            F3_W:        return (addr_lo != 2'b00);
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the data memory: store lane enables and
// lane-replicated write data, plus sign/zero extension of load data
// picked out of a naturally aligned 32-bit word.
module lsu_align
    import mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] raw_rdata,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext
);

    logic [4:0]  shamt;
    logic [31:0] shifted;

    assign shamt   = {addr_lo, 3'b000};
    assign shifted = raw_rdata >> shamt;

    // Decode size/sign into lane enables, replicated store data and extended load data.
    always_comb begin
        byte_en    = 4'b0000;
        wdata_lane = 32'h0;
        rdata_ext  = 32'h0;
        case (funct3_t'(funct3))
            F3_B: begin
                byte_en    = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = {{24{shifted[7]}}, shifted[7:0]};
            end
            F3_BU: begin
                byte_en    = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = {24'h0, shifted[7:0]};
            end
            F3_H: begin
                byte_en    = 4'b0011 << addr_lo;
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = {{16{shifted[15]}}, shifted[15:0]};
            end
            F3_HU: begin
                byte_en    = 4'b0011 << addr_lo;
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = {16'h0, shifted[15:0]};
            end
            F3_W: begin
                byte_en    = 4'b1111;
                wdata_lane = wdata;
                rdata_ext  = raw_rdata;
            end
            default: begin
                byte_en    = 4'b0000;
                wdata_lane = 32'h0;
                rdata_ext  = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/lsu_data_memory.sv
// Request/response byte-addressed data memory for the RV32I core.
// Handshake: a request is accepted on a rising edge where req_valid and
// req_ready are both high; the response is a single-cycle rsp_valid pulse
// with rsp_rdata/rsp_err, which the requester must take (no backpressure).
module lsu_data_memory
    import mem_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0]           DEPTH_BYTES = 32'h0002_0000,
    parameter int                    WAIT_STATES = 0,
    parameter string                 INIT_FILE   = "",
    parameter logic [31:0]           INIT_OFFSET = 32'h0001_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [2:0]            req_funct3,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);

    localparam int IDX_W = $clog2(DEPTH_BYTES);

    if (DATA_WIDTH != 32) begin : g_bad_data_width
        $error("lsu_data_memory: DATA_WIDTH must be 32");
    end
    if ((DEPTH_BYTES < 4) || ((DEPTH_BYTES & (DEPTH_BYTES - 1)) != 0)) begin : g_bad_depth
        $error("lsu_data_memory: DEPTH_BYTES must be a power of two >= 4");
    end
    if (IDX_W > ADDR_WIDTH) begin : g_bad_addr_width
        $error("lsu_data_memory: DEPTH_BYTES does not fit in ADDR_WIDTH");
    end
    if ((WAIT_STATES < 0) || (WAIT_STATES > 15)) begin : g_bad_wait
        $error("lsu_data_memory: WAIT_STATES must be 0..15");
    end

    mem_state_t            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] off_q, off_d;
    logic [2:0]            f3_q, f3_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    logic [7:0] mem_q [0:DEPTH_BYTES-1];

    // The access being evaluated: the incoming request while idle (so a
    // zero-wait response can be formed at the accept edge), otherwise the
    // latched one.
    logic                  in_idle;
    logic                  src_we;
    logic [ADDR_WIDTH-1:0] src_off;
    logic [2:0]            src_f3;
    logic [DATA_WIDTH-1:0] src_wdata;
    logic [2:0]            src_size;
    logic [ADDR_WIDTH:0]   src_end;
    logic                  src_fault;
    logic [31:0]           raw_word;
    logic [3:0]            byte_en;
    logic [31:0]           wdata_lane;
    logic [31:0]           rdata_ext;
    logic                  enter_resp;
    logic                  wr_en;

    assign in_idle   = (state_q == S_IDLE);
    assign src_we    = in_idle ? req_we : we_q;
    assign src_off   = in_idle ? (req_addr - BASE_ADDR) : off_q;
    assign src_f3    = in_idle ? req_funct3 : f3_q;
    assign src_wdata = in_idle ? req_wdata : wdata_q;

    // Offset + size is formed one bit wider so wrapped offsets cannot alias back in range.
    assign src_size  = access_size(funct3_t'(src_f3));
    assign src_end   = {1'b0, src_off} + {{(ADDR_WIDTH-2){1'b0}}, src_size};
    assign src_fault = (src_size == SIZE_NONE)
                     || is_misaligned(funct3_t'(src_f3), src_off[1:0])
                     || (src_end > (ADDR_WIDTH+1)'(DEPTH_BYTES));

    // Gather the naturally aligned word containing the access, little-endian.
    always_comb begin
        raw_word = 32'h0;
        for (int i = 0; i < 4; i++) begin
            raw_word[8*i +: 8] = mem_q[{src_off[IDX_W-1:2], 2'(i)}];
        end
    end

    lsu_align u_align (
        .funct3     (src_f3),
        .addr_lo    (src_off[1:0]),
        .wdata      (src_wdata),
        .raw_rdata  (raw_word),
        .byte_en    (byte_en),
        .wdata_lane (wdata_lane),
        .rdata_ext  (rdata_ext)
    );

    // Next-state logic: accept and latch in IDLE, count down in WAIT, one cycle of RESP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        off_d   = off_q;
        f3_d    = f3_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    off_d   = req_addr - BASE_ADDR;
                    f3_d    = req_funct3;
                    wdata_d = req_wdata;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Response registers load on the edge that enters RESP.
    always_comb begin
        enter_resp  = (state_d == S_RESP) && (state_q != S_RESP);
        rsp_valid_d = enter_resp;
        rsp_err_d   = enter_resp && src_fault;
        rsp_rdata_d = (enter_resp && !src_fault && !src_we) ? rdata_ext : '0;
    end

    // Control and response state, cleared asynchronously so reset drops any request in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            off_q       <= '0;
            f3_q        <= 3'd0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            off_q       <= off_d;
            f3_q        <= f3_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign wr_en = (state_q == S_RESP) && we_q && !src_fault;

    // Legal stores commit their byte lanes on the edge leaving RESP; the array is never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem_q[{off_q[IDX_W-1:2], 2'(i)}] <= wdata_lane[8*i +: 8];
                end
            end
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_lsu_data_memory.sv
// Bench for lsu_data_memory: instance 0 has no wait states, instance 1 has
// three. A byte-level reference memory keyed by (instance, offset) predicts
// every load, fault and latency.
module tb_lsu_data_memory;

  localparam longint TB_DEPTH = 64'h0002_0000;
  localparam logic [31:0] TB_BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n      [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [31:0] req_addr   [2];
  logic [2:0]  req_funct3 [2];
  logic [31:0] req_wdata  [2];
  logic        rsp_valid  [2];
  logic [31:0] rsp_rdata  [2];
  logic        rsp_err    [2];

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mdl [longint];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  lsu_data_memory #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_funct3(req_funct3[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0])
  );

  lsu_data_memory #(.WAIT_STATES(3)) dut3 (
    .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_funct3(req_funct3[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1])
  );

  // ---------------- reference model ----------------
  function automatic longint mkey(input int sel, input logic [31:0] off);
    return (longint'(sel) << 40) | longint'(off);
  endfunction

  function automatic void model_op(input int sel, input logic we, input logic [31:0] addr,
                                   input logic [2:0] f3, input logic [31:0] wd,
                                   output logic [31:0] rd, output logic er);
    int size;
    bit sgn;
    longint v;
    logic [31:0] off;
    size = 0;
    sgn = 0;
    case (f3)
      3'd0: begin size = 1; sgn = 1; end
      3'd1: begin size = 2; sgn = 1; end
      3'd2: size = 4;
      3'd4: size = 1;
      3'd5: size = 2;
      default: size = 0;
    endcase
    off = addr - TB_BASE;
    rd = 32'h0;
    er = 1'b0;
    if (size == 0) er = 1'b1;
    else if ((addr % size) != 0) er = 1'b1;
    else if (longint'(off) + size > TB_DEPTH) er = 1'b1;
    if (er) return;
    if (we) begin
      for (int i = 0; i < size; i++) mdl[mkey(sel, off + i)] = wd[8*i +: 8];
    end else begin
      v = 0;
      for (int i = 0; i < size; i++) begin
        longint k;
        k = mkey(sel, off + i);
        v += (mdl.exists(k) ? longint'(mdl[k]) : 64'd0) << (8 * i);
      end
      if (sgn && v >= (longint'(1) << (8 * size - 1))) v -= longint'(1) << (8 * size);
      rd = v[31:0];
    end
  endfunction

  // ---------------- driver tasks ----------------
  // Issues one request from a negedge; returns response data and the
  // number of cycles from the accept edge to the rsp_valid sample.
  task automatic access(input int sel, input logic we, input logic [31:0] addr,
                        input logic [2:0] f3, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    int guard;
    req_valid[sel] = 1'b1;
    req_we[sel] = we;
    req_addr[sel] = addr;
    req_funct3[sel] = f3;
    req_wdata[sel] = wd;
    guard = 0;
    while (req_ready[sel] !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    req_valid[sel] = 1'b0;
    lat = 1;
    while (rsp_valid[sel] !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = rsp_rdata[sel];
    er = rsp_err[sel];
    if (rsp_valid[sel] !== 1'b1) begin
      n_checks++;
      n_errors++;
      $display("FAIL rsp_timeout sel=%0d addr=%h: no rsp_valid within %0d cycles", sel, addr, lat);
    end
  endtask

  // Runs one access and the model side by side, returning both results.
  task automatic run_op(input int sel, input logic we, input logic [31:0] addr,
                        input logic [2:0] f3, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat,
                        output logic [31:0] exp_rd, output logic exp_er);
    access(sel, we, addr, f3, wd, rd, er, lat);
    model_op(sel, we, addr, f3, wd, exp_rd, exp_er);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      rst_n[s] = 1'b0;
      req_valid[s] = 1'b0;
      req_we[s] = 1'b0;
      req_addr[s] = 32'h0;
      req_funct3[s] = 3'd0;
      req_wdata[s] = 32'h0;
    end
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      n_checks++;
      if (req_ready[s] !== 1'b1 || rsp_valid[s] !== 1'b0 || rsp_rdata[s] !== 32'h0 || rsp_err[s] !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_hold sel=%0d: ready=%b valid=%b rdata=%h err=%b, want 1 0 0 0",
                 s, req_ready[s], rsp_valid[s], rsp_rdata[s], rsp_err[s]);
      end
    end
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      n_checks++;
      if (req_ready[s] !== 1'b1 || rsp_valid[s] !== 1'b0 || rsp_rdata[s] !== 32'h0 || rsp_err[s] !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_release sel=%0d: ready=%b valid=%b rdata=%h err=%b, want 1 0 0 0",
                 s, req_ready[s], rsp_valid[s], rsp_rdata[s], rsp_err[s]);
      end
    end
  endtask

  task automatic test_word_round_trip();
    logic [31:0] rd, erd;
    logic er, eer;
    int lat;
    run_op(0, 1'b1, 32'h100, 3'd2, 32'hDEAD_BEEF, rd, er, lat, erd, eer);
    n_checks++;
    if (rd !== 32'h0 || er !== 1'b0 || lat != 1) begin
      n_errors++;
      $display("FAIL sw_0x100: rdata=%h err=%b lat=%0d, want 0 0 1", rd, er, lat);
    end
    run_op(0, 1'b0, 32'h100, 3'd2, 32'h0, rd, er, lat, erd, eer);
    n_checks++;
    if (rd !== 32'hDEAD_BEEF || er !== 1'b0 || lat != 1) begin
      n_errors++;
      $display("FAIL lw_0x100: rdata=%h err=%b lat=%0d, want deadbeef 0 1", rd, er, lat);
    end
  endtask

  task automatic test_extension();
    logic [2:0]  f3s  [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
    logic [31:0] adrs [4] = '{32'h103, 32'h103, 32'h100, 32'h102};
    logic [31:0] exps [4] = '{32'hFFFF_FFDE, 32'h0000_00DE, 32'hFFFF_BEEF, 32'h0000_DEAD};
    logic [31:0] rd, erd;
    logic er, eer;
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(0, 1'b0, adrs[i], f3s[i], 32'h0, rd, er, lat, erd, eer);
      n_checks++;
      if (rd !== exps[i] || er !== 1'b0) begin
        n_errors++;
        $display("FAIL extend f3=%0d addr=%h: rdata=%h err=%b, want %h 0", f3s[i], adrs[i], rd, er, exps[i]);
      end
    end
  endtask

  task automatic test_partial_stores();
    logic [31:0] rd, erd;
    logic er, eer;
    int lat;
    run_op(0, 1'b1, 32'h101, 3'd0, 32'hFFFF_FF55, rd, er, lat, erd, eer);
    run_op(0, 1'b1, 32'h102, 3'd1, 32'hABCD_1234, rd, er, lat, erd, eer);
    run_op(0, 1'b0, 32'h100, 3'd2, 32'h0, rd, er, lat, erd, eer);
    n_checks++;
    if (rd !== 32'h1234_55EF || er !== 1'b0) begin
      n_errors++;
      $display("FAIL partial_store: rdata=%h err=%b, want 123455ef 0", rd, er);
    end
  endtask

  task automatic test_faults();
    logic        wes  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [2:0]  f3s  [6] = '{3'd2, 3'd1, 3'd2, 3'd3, 3'd2, 3'd7};
    logic [31:0] adrs [6] = '{32'h102, 32'h101, 32'h1_FFFE, 32'h100, 32'h2_0000, 32'h100};
    logic [31:0] rd, erd;
    logic er, eer;
    int lat;
    for (int i = 0; i < 6; i++) begin
      run_op(0, wes[i], adrs[i], f3s[i], 32'hCAFE_F00D, rd, er, lat, erd, eer);
      n_checks++;
      if (rd !== 32'h0 || er !== 1'b1) begin
        n_errors++;
        $display("FAIL fault_%0d f3=%0d addr=%h: rdata=%h err=%b, want 0 1", i, f3s[i], adrs[i], rd, er);
      end
    end
    run_op(0, 1'b0, 32'h100, 3'd2, 32'h0, rd, er, lat, erd, eer);
    n_checks++;
    if (rd !== 32'h1234_55EF || er !== 1'b0) begin
      n_errors++;
      $display("FAIL fault_no_write: rdata=%h err=%b, want 123455ef 0", rd, er);
    end
    // Last legal byte and word of the region.
    run_op(0, 1'b1, 32'h1_FFFC, 3'd2, 32'h8877_6655, rd, er, lat, erd, eer);
    run_op(0, 1'b0, 32'h1_FFFF, 3'd0, 32'h0, rd, er, lat, erd, eer);
    n_checks++;
    if (rd !== 32'hFFFF_FF88 || er !== 1'b0) begin
      n_errors++;
      $display("FAIL top_byte: rdata=%h err=%b, want ffffff88 0", rd, er);
    end
  endtask

  task automatic test_random();
    logic [2:0] f3_pool [13] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    logic [31:0] rd, erd, addr;
    logic er, eer, we;
    logic [2:0] f3;
    int lat, sel;
    for (int s = 0; s < 2; s++) begin
      for (int w = 0; w < 16; w++) begin
        run_op(s, 1'b1, 32'h400 + 32'(4 * w), 3'd2, $urandom, rd, er, lat, erd, eer);
        n_checks++;
        if (er !== 1'b0 || lat != (s == 1 ? 4 : 1)) begin
          n_errors++;
          $display("FAIL rand_init sel=%0d w=%0d: err=%b lat=%0d", s, w, er, lat);
        end
      end
    end
    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(0, 1);
      we = ($urandom_range(0, 2) == 0);
      f3 = f3_pool[$urandom_range(0, 12)];
      if ($urandom_range(0, 9) == 0) addr = 32'hFFFF_FF00 + 32'($urandom_range(0, 255));
      else addr = 32'h400 + 32'($urandom_range(0, 63));
      run_op(sel, we, addr, f3, $urandom, rd, er, lat, erd, eer);
      n_checks++;
      if (rd !== erd || er !== eer || lat != (sel == 1 ? 4 : 1)) begin
        n_errors++;
        $display("FAIL rand_%0d sel=%0d we=%b f3=%0d addr=%h: rdata=%h err=%b lat=%0d, want %h %b %0d",
                 n, sel, we, f3, addr, rd, er, lat, erd, eer, (sel == 1 ? 4 : 1));
      end
    end
  endtask

  // Holds req_valid high across two loads and checks accept spacing and response timing.
  task automatic test_back_to_back(input int sel);
    int ws, period, guard;
    logic [31:0] exp0, exp1;
    logic e0, e1, exp_rdy, exp_vld;
    ws = (sel == 1) ? 3 : 0;
    period = ws + 2;
    model_op(sel, 1'b0, 32'h408, 3'd2, 32'h0, exp0, e0);
    model_op(sel, 1'b0, 32'h40E, 3'd5, 32'h0, exp1, e1);
    guard = 0;
    while (req_ready[sel] !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    req_valid[sel] = 1'b1;
    req_we[sel] = 1'b0;
    req_addr[sel] = 32'h408;
    req_funct3[sel] = 3'd2;
    for (int c = 1; c <= 2 * period - 1; c++) begin
      @(negedge clk);
      exp_rdy = ((c % period) == 0);
      exp_vld = ((c % period) == ws + 1);
      n_checks++;
      if (req_ready[sel] !== exp_rdy || rsp_valid[sel] !== exp_vld) begin
        n_errors++;
        $display("FAIL b2b sel=%0d cycle=%0d: ready=%b valid=%b, want %b %b",
                 sel, c, req_ready[sel], rsp_valid[sel], exp_rdy, exp_vld);
      end
      if (exp_vld) begin
        n_checks++;
        if (rsp_rdata[sel] !== (c == ws + 1 ? exp0 : exp1) || rsp_err[sel] !== 1'b0) begin
          n_errors++;
          $display("FAIL b2b_data sel=%0d cycle=%0d: rdata=%h err=%b, want %h 0",
                   sel, c, rsp_rdata[sel], rsp_err[sel], (c == ws + 1 ? exp0 : exp1));
        end
      end
      if (c == 1) begin
        req_addr[sel] = 32'h40E;
        req_funct3[sel] = 3'd5;
      end
      if (c == period + 1) req_valid[sel] = 1'b0;
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] rd, erd;
    logic er, eer;
    int lat, guard;
    run_op(1, 1'b1, 32'h200, 3'd2, 32'h0, rd, er, lat, erd, eer);
    run_op(1, 1'b1, 32'h204, 3'd2, 32'h0, rd, er, lat, erd, eer);
    // Reset while in WAIT.
    guard = 0;
    while (req_ready[1] !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'h200;
    req_funct3[1] = 3'd2; req_wdata[1] = 32'hAAAA_AAAA;
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(negedge clk);
    rst_n[1] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n[1] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_checks++;
      if (rsp_valid[1] !== 1'b0) begin
        n_errors++;
        $display("FAIL rst_wait_rsp cycle=%0d: rsp_valid=%b, want 0", c, rsp_valid[1]);
      end
    end
    run_op(1, 1'b0, 32'h200, 3'd2, 32'h0, rd, er, lat, erd, eer);
    n_checks++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_wait_store: rdata=%h err=%b, want 0 0", rd, er);
    end
    // Reset while in RESP: the pending store must not commit.
    guard = 0;
    while (req_ready[1] !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'h204;
    req_funct3[1] = 3'd2; req_wdata[1] = 32'hBBBB_BBBB;
    @(negedge clk);
    req_valid[1] = 1'b0;
    guard = 0;
    while (rsp_valid[1] !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
    rst_n[1] = 1'b0;
    #1;
    n_checks++;
    if (rsp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_resp_async: rsp_valid=%b ready=%b, want 0 1", rsp_valid[1], req_ready[1]);
    end
    repeat (2) @(negedge clk);
    rst_n[1] = 1'b1;
    @(negedge clk);
    run_op(1, 1'b0, 32'h204, 3'd2, 32'h0, rd, er, lat, erd, eer);
    n_checks++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_resp_store: rdata=%h err=%b, want 0 0", rd, er);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_word_round_trip();
    test_extension();
    test_partial_stores();
    test_faults();
    test_random();
    test_back_to_back(0);
    test_back_to_back(1);
    test_reset_mid_op();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
